// File: rtl/channel_poll.sv
// channel_poll: round-robin scheduler in front of the per-channel packet checker.
// Steps through channel FIFOs 1..NCH. For each channel it latches the channel number on
// tongdao, pulses start, and waits for the checker's over pulse (or a timeout) before it
// moves on. The selected FIFO's fill level and data are muxed to the checker, and the
// checker's rdreq is steered back to that FIFO only.
//
// Optional feature: define POLL_SKIP_EMPTY_EN to skip channels whose fill level is
// below YUZHI without issuing a start.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   en            polling enable (level)
//   rdusedw_bus   NCH x 12-bit FIFO fill levels, channel k at [(k-1)*12 +: 12]
//   fifo_out_bus  NCH x 64-bit FIFO read data, channel k at [(k-1)*64 +: 64]
//   rdreq_bus     per-FIFO read request, bit k-1 is channel k
//   rdusedw       fill level of the selected channel
//   fifo_out      read data of the selected channel
//   rdreq         read request from the checker
//   tongdao       selected channel number 1..NCH, zero-extended
//   start         one-cycle pulse to the checker
//   over          checker done pulse
//   busy          high in every state except idle
//   err           sticky timeout flag
//   rounds        completed full passes, wraps modulo 2^32
module channel_poll #(
   parameter int unsigned NCH     = 30,
   parameter int unsigned YUZHI   = 128,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NCH*12-1:0] rdusedw_bus,
   input  logic [NCH*64-1:0] fifo_out_bus,
   output logic [NCH-1:0]    rdreq_bus,
   output logic [11:0]       rdusedw,
   output logic [63:0]       fifo_out,
   input  logic              rdreq,
   output logic [31:0]       tongdao,
   output logic              start,
   input  logic              over,
   output logic              busy,
   output logic              err,
   output logic [31:0]       rounds
);

   localparam int unsigned ChW  = $clog2(NCH + 1);
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

`ifdef POLL_SKIP_EMPTY_EN
   localparam bit SkipEn = 1'b1;
`else
   localparam bit SkipEn = 1'b0;
`endif

   typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StNext} state_e;

   state_e            state_q, state_d;
   logic [ChW-1:0]    ch_q, ch_d;
   logic [ChW-1:0]    tongdao_q, tongdao_d;
   logic              start_q, start_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic [31:0]       rounds_q, rounds_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic [11:0]       ch_lvl;
   logic              ch_below;

   // Checker-facing muxes, driven from the registered channel so the selection
   // cannot change while the checker is reading.
   always_comb begin
      rdusedw   = '0;
      fifo_out  = '0;
      rdreq_bus = '0;
      for (int k = 0; k < NCH; k++) begin
         if (tongdao_q == ChW'(k + 1)) begin
            rdusedw      = rdusedw_bus[k*12 +: 12];
            fifo_out     = fifo_out_bus[k*64 +: 64];
            rdreq_bus[k] = rdreq;
         end
      end
   end

   // Skip decision looks at the channel about to be loaded, not the current tongdao.
   always_comb begin
      ch_lvl = '0;
      for (int k = 0; k < NCH; k++) begin
         if (ch_q == ChW'(k + 1)) begin
            ch_lvl = rdusedw_bus[k*12 +: 12];
         end
      end
      ch_below = (32'(ch_lvl) < YUZHI);
   end

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      tongdao_d = tongdao_q;
      start_d   = 1'b0;
      err_d     = err_q;
      rounds_d  = rounds_q;
      cnt_d     = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (en) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            tongdao_d = ch_q;
            if (SkipEn && ch_below) begin
               state_d = StNext;
            end else begin
               state_d = StStart;
               start_d = 1'b1;  // registered: high during StStart
            end
         end
         StStart: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            // over wins over a simultaneous timeout
            if (over) begin
               state_d = StNext;
            end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = StNext;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StNext: begin
            if (ch_q == ChW'(NCH)) begin
               ch_d     = ChW'(1);
               rounds_d = rounds_q + 32'd1;
            end else begin
               ch_d = ch_q + 1'b1;
            end
            state_d = en ? StLoad : StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         ch_q      <= ChW'(1);
         tongdao_q <= ChW'(1);
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         rounds_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         tongdao_q <= tongdao_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         rounds_q  <= rounds_d;
         cnt_q     <= cnt_d;
      end
   end

   assign tongdao = 32'(tongdao_q);
   assign start   = start_q;
   assign busy    = busy_q;
   assign err     = err_q;
   assign rounds  = rounds_q;

endmodule

// File: tb/tb_channel_poll.sv
module tb_channel_poll;

   localparam int NCH     = 30;
   localparam int YUZHI   = 128;
   localparam int TIMEOUT = 16;
   localparam int LAT     = 5;   // checker model: over this many cycles after start

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic [NCH*12-1:0] rdusedw_bus;
   logic [NCH*64-1:0] fifo_out_bus;
   logic [NCH-1:0]    rdreq_bus;
   logic [11:0]       rdusedw;
   logic [63:0]       fifo_out;
   logic              rdreq;
   logic [31:0]       tongdao;
   logic              start;
   logic              over;
   logic              over_model;
   logic              over_stray;
   logic              busy;
   logic              err;
   logic [31:0]       rounds;

   int          n_cmp  = 0;
   int          n_fail = 0;
   int          exp_q[$];
   int          starts_seen [0:NCH];
   logic [NCH:0] hang;
   logic [11:0] lvl [0:NCH];
   logic [63:0] dat [0:NCH];
   int          model_cnt = 0;
   int          mon_e;
   int          n;
   int          once;

   assign over = over_model | over_stray;

   channel_poll #(
      .NCH     (NCH),
      .YUZHI   (YUZHI),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .rdusedw_bus  (rdusedw_bus),
      .fifo_out_bus (fifo_out_bus),
      .rdreq_bus    (rdreq_bus),
      .rdusedw      (rdusedw),
      .fifo_out     (fifo_out),
      .rdreq        (rdreq),
      .tongdao      (tongdao),
      .start        (start),
      .over         (over),
      .busy         (busy),
      .err          (err),
      .rounds       (rounds)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a start pulse carrying channel ch; n_out = negedges waited.
   task automatic wait_start(input int ch, input int budget, output int n_out);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(start === 1'b1 && tongdao == 32'(ch)) && k < budget);
      chk($sformatf("wait_start_ch%0d", ch), {63'd0, (start === 1'b1 && tongdao == 32'(ch))},
          64'd1);
      n_out = k;
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_start"},     {63'd0, start},     64'd0);
      chk({pfx, "_busy"},      {63'd0, busy},      64'd0);
      chk({pfx, "_tongdao"},   {32'd0, tongdao},   64'd1);
      chk({pfx, "_err"},       {63'd0, err},       64'd0);
      chk({pfx, "_rounds"},    {32'd0, rounds},    64'd0);
      chk({pfx, "_rdreq_bus"}, {34'd0, rdreq_bus}, 64'd0);
   endtask

   // Checker model: answers each start with over LAT cycles later unless the channel hangs.
   initial begin
      over_model = 1'b0;
      forever begin
         @(negedge clk);
         over_model = 1'b0;
         if (model_cnt > 0) begin
            model_cnt--;
            if (model_cnt == 0) over_model = 1'b1;
         end
         if (start === 1'b1 && !hang[tongdao]) model_cnt = LAT;
      end
   end

   // Scoreboard: every start pops the next expected channel.
   initial begin
      for (int k = 0; k <= NCH; k++) starts_seen[k] = 0;
      forever begin
         @(negedge clk);
         if (start === 1'b1) begin
            if (tongdao <= 32'(NCH)) starts_seen[tongdao]++;
            chk("start_expected", {63'd0, (exp_q.size() > 0)}, 64'd1);
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               chk("start_tongdao", {32'd0, tongdao}, 64'(mon_e));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      en         = 1'b1;
      rdreq      = 1'b0;
      over_stray = 1'b0;
      hang       = '0;
      for (int k = 1; k <= NCH; k++) begin
`ifdef POLL_SKIP_EMPTY_EN
         lvl[k] = (k == 5) ? 12'd128 : 12'd0;
`else
         lvl[k] = (k == 7) ? 12'd200 : 12'(k * 5);
`endif
         dat[k] = {32'hC0DE_0000 | 32'(k), 32'h0101_0101 * 32'(k)};
         rdusedw_bus[(k-1)*12 +: 12]  = lvl[k];
         fifo_out_bus[(k-1)*64 +: 64] = dat[k];
      end
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");

`ifdef POLL_SKIP_EMPTY_EN
      exp_q.push_back(5);
      exp_q.push_back(5);
      rst = 1'b0;
      wait_start(5, 200, n);
      wait_start(5, 200, n);
      // LOAD+START, LAT wait cycles, NEXT, then two cycles per skipped channel
      chk("skip_pass_period", 64'(n), 64'(2 * (NCH - 1) + 2 + LAT + 1));
      chk("skip_rounds", {32'd0, rounds}, 64'd1);
`else
      for (int k = 1; k <= NCH; k++) exp_q.push_back(k);
      exp_q.push_back(1);
      rst = 1'b0;

      // Full pass
      n = 0;
      while (rounds !== 32'd1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("rounds_after_pass", {32'd0, rounds}, 64'd1);
      once = 0;
      for (int k = 1; k <= NCH; k++) if (starts_seen[k] == 1) once++;
      chk("one_start_per_ch", 64'(once), 64'(NCH));

      // Timeout on channel 3
      hang[3] = 1'b1;
      for (int k = 2; k <= 12; k++) exp_q.push_back(k);
      wait_start(3, 100, n);
      chk("err_before_timeout", {63'd0, err}, 64'd0);
      n = 0;
      while (err !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      // WAIT is entered one cycle after start; err shows TIMEOUT cycles after that
      chk("timeout_latency", 64'(n), 64'(TIMEOUT + 1));
      wait_start(4, 40, n);
      chk("err_sticky", {63'd0, err}, 64'd1);

      // Mux and rdreq steering on channel 7
      wait_start(7, 100, n);
      @(negedge clk);
      rdreq = 1'b1;
      #1;
      chk("ch7_rdusedw",   {52'd0, rdusedw},   64'd200);
      chk("ch7_rdreq_bus", {34'd0, rdreq_bus}, 64'h40);
      chk("ch7_fifo_out",  fifo_out,           dat[7]);
      rdreq = 1'b0;
      #1;
      chk("ch7_rdreq_low", {34'd0, rdreq_bus}, 64'd0);

      // en dropped while channel 12 is in progress
      wait_start(12, 100, n);
      en = 1'b0;
      n = 0;
      while (busy !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      chk("idle_busy",    {63'd0, busy},      64'd0);
      chk("idle_tongdao", {32'd0, tongdao},   64'd12);
      chk("idle_queue",   64'(exp_q.size()),  64'd0);
      for (int k = 13; k <= 20; k++) exp_q.push_back(k);
      en = 1'b1;
      wait_start(13, 20, n);

      // Reset while waiting on channel 20, then a stray over
      wait_start(20, 200, n);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      en  = 1'b0;
      @(negedge clk);
      chk_reset_vals("midreset");
      rst = 1'b0;
      over_stray = 1'b1;
      @(negedge clk);
      over_stray = 1'b0;
      repeat (10) @(negedge clk);
      chk("stray_busy",    {63'd0, busy},    64'd0);
      chk("stray_tongdao", {32'd0, tongdao}, 64'd1);
      chk("stray_rounds",  {32'd0, rounds},  64'd0);
      exp_q.push_back(1);
      en = 1'b1;
      wait_start(1, 20, n);
`endif
      repeat (2) @(negedge clk);
      chk("final_queue", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
